acc_predecoder_arb: RTL

- Multi-port, registered successor of the accelerator offload predecoder.
- Up to NumPorts cores present 32-bit instruction words. A round-robin arbiter admits one per cycle and matches it against a compile-time offload table.
- The predecode result (accept, writeback, use_rs, operand/immediate mux selects, matched index, source port) is returned through a one-deep valid/ready output register.
- Sits between the core issue stages and the shared accelerator interconnect. Adds per-port saturating reject counters for performance monitoring.

---
 rtl/acc_pkg.sv | 83 ++++++++
 rtl/acc_predecoder_match.sv | 31 +++
 rtl/acc_predecoder_arb.sv | 121 ++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared types for the accelerator offload predecoder: offload table entries,
// operand/immediate selects and the registered predecode response.
package acc_pkg;

  // Fixed field widths so the response type does not depend on instance parameters.
  localparam int unsigned PREDEC_PORT_W = 8;
  localparam int unsigned PREDEC_IDX_W  = 8;

  typedef enum logic [1:0] {
    OP_RS   = 2'd0,
    OP_IMM  = 2'd1,
    OP_PC   = 2'd2,
    OP_NONE = 2'd3
  } op_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef struct packed {
    logic [31:0] instr_data;
    logic [31:0] instr_mask;
    logic [1:0]  writeback;
    logic [2:0]  use_rs;
    op_sel_e     op_a_mux;
    op_sel_e     op_b_mux;
    op_sel_e     op_c_mux;
    imm_sel_e    imm_a_mux;
    imm_sel_e    imm_b_mux;
    imm_sel_e    imm_c_mux;
  } offl_instr_t;

  typedef struct packed {
    logic [PREDEC_PORT_W-1:0] port;
    logic                     accept;
    logic [PREDEC_IDX_W-1:0]  match_idx;
    logic [1:0]               writeback;
    logic [2:0]               use_rs;
    op_sel_e                  op_a_mux;
    op_sel_e                  op_b_mux;
    op_sel_e                  op_c_mux;
    imm_sel_e                 imm_a_mux;
    imm_sel_e                 imm_b_mux;
    imm_sel_e                 imm_c_mux;
  } predec_rsp_t;

  localparam predec_rsp_t PREDEC_RSP_DEFAULT = '{
    port:      '0,
    accept:    1'b0,
    match_idx: '0,
    writeback: 2'b00,
    use_rs:    3'b000,
    op_a_mux:  OP_RS,
    op_b_mux:  OP_RS,
    op_c_mux:  OP_RS,
    imm_a_mux: IMM_I,
    imm_b_mux: IMM_I,
    imm_c_mux: IMM_I
  };

  // Accepted response for table entry e at index idx; port is filled in by the arbiter.
  function automatic predec_rsp_t predec_from_entry(input offl_instr_t             e,
                                                    input logic [PREDEC_IDX_W-1:0] idx);
    predec_rsp_t r;
    r           = PREDEC_RSP_DEFAULT;
    r.accept    = 1'b1;
    r.match_idx = idx;
    r.writeback = e.writeback;
    r.use_rs    = e.use_rs;
    r.op_a_mux  = e.op_a_mux;
    r.op_b_mux  = e.op_b_mux;
    r.op_c_mux  = e.op_c_mux;
    r.imm_a_mux = e.imm_a_mux;
    r.imm_b_mux = e.imm_b_mux;
    r.imm_c_mux = e.imm_c_mux;
    return r;
  endfunction

endpackage

// File: rtl/acc_predecoder_match.sv
// Combinational offload-table lookup for one instruction word; the lowest
// matching entry wins, no match returns the default response.
module acc_predecoder_match
  import acc_pkg::*;
#(
  parameter int unsigned NumInstr = 1,
  parameter offl_instr_t [(NumInstr > 0 ? NumInstr : 1)-1:0] offl_instr = '0
) (
  input  logic [31:0] instr_i,
  output predec_rsp_t rsp_o
);

  localparam int unsigned NumEntries = (NumInstr > 0) ? NumInstr : 1;
  localparam int unsigned IdxW       = (NumEntries > 1) ? $clog2(NumEntries) : 1;

  logic found;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rsp_o = PREDEC_RSP_DEFAULT;
    found = 1'b0;
    for (int unsigned i = 0; i < NumInstr; i++) begin
      if (!found &&
          ((instr_i & offl_instr[IdxW'(i)].instr_mask) == offl_instr[IdxW'(i)].instr_data)) begin
        found = 1'b1;
        rsp_o = predec_from_entry(offl_instr[IdxW'(i)], PREDEC_IDX_W'(i));
      end
    end
  end

endmodule

// File: rtl/acc_predecoder_arb.sv
// Multi-port predecoder: round-robin admits one core request per cycle, looks it
// up in the offload table and returns the result through a one-deep output register.
module acc_predecoder_arb
  import acc_pkg::*;
#(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned NumInstr = 1,
  parameter offl_instr_t [(NumInstr > 0 ? NumInstr : 1)-1:0] offl_instr = '0,
  parameter int unsigned CntW = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumPorts-1:0]              req_valid_i,
  output logic [NumPorts-1:0]              req_ready_o,
  input  logic [NumPorts-1:0][31:0]        req_instr_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output predec_rsp_t                      rsp_o,
  output logic [NumPorts-1:0][CntW-1:0]    rej_cnt_o,
  input  logic                             rej_clr_i
);

  // PortW must not exceed PREDEC_PORT_W for the port field to hold every index.
  localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [PortW-1:0] ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  predec_rsp_t      rsp_q, rsp_d;

  logic [PortW-1:0] cand;
  logic [PortW-1:0] grant_idx;
  logic             grant_valid;
  logic             out_free;
  logic             req_hs;
  predec_rsp_t      match_rsp;

  // Round-robin search starting at the pointer, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      cand = PortW'((32'(ptr_q) + k) % NumPorts);
      if (!grant_valid && req_valid_i[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Ready is held low during reset so no request is consumed by a cycle that gets discarded.
  assign out_free = rst_ni & (~rsp_valid_q | rsp_ready_i);
  assign req_hs   = grant_valid & out_free;

  always_comb begin
    req_ready_o = '0;
    if (req_hs) req_ready_o[grant_idx] = 1'b1;
  end

  acc_predecoder_match #(
    .NumInstr   (NumInstr),
    .offl_instr (offl_instr)
  ) u_match (
    .instr_i (req_instr_i[grant_idx]),
    .rsp_o   (match_rsp)
  );

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    if (req_hs) begin
      ptr_d       = (grant_idx == PortW'(NumPorts - 1)) ? '0 : grant_idx + 1'b1;
      rsp_valid_d = 1'b1;
      rsp_d       = match_rsp;
      rsp_d.port  = PREDEC_PORT_W'(grant_idx);
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: the reset branch clears every state flop, including the response payload, so a dropped transfer leaves nothing stale.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= PREDEC_RSP_DEFAULT;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_o       = rsp_q;

  for (genvar g = 0; g < NumPorts; g++) begin : g_rej
    logic [CntW-1:0] rej_cnt_q, rej_cnt_d;

    // Clear wins over a same-cycle reject; the counter sticks at all-ones.
    always_comb begin
      rej_cnt_d = rej_cnt_q;
      if (rej_clr_i) begin
        rej_cnt_d = '0;
      end else if (req_hs && !match_rsp.accept && (grant_idx == PortW'(g)) &&
                   (rej_cnt_q != {CntW{1'b1}})) begin
        rej_cnt_d = rej_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) rej_cnt_q <= '0;
      else         rej_cnt_q <= rej_cnt_d;
    end

    assign rej_cnt_o[g] = rej_cnt_q;
  end

endmodule
